ntt_stage_sequencer: RTL and testbench
======================================

// Module: ntt_stage_sequencer
// PURPOSE
//  Sole source of addresses and mode for butterfly_unit; runs a whole NTT, inverse NTT or element-wise pass.
//  Sweeps all LOG_N stages, issuing one butterfly per cycle: coefficient-RAM read addresses, twiddle index, mode bits.
//  Delays the read addresses by the read + butterfly latency to generate matching RAM write-back addresses and enables.
//  Drains the pipeline between stages so stage s+1 never reads a location before stage s has written it.
// PARAMETERS
//  LOG_N    4   log2 of polynomial length N (N = 2**LOG_N coefficients, N/2 butterflies per stage)
//  RD_LAT   1   coefficient/twiddle RAM read latency, cycles (address to data)
//  BFU_LAT  17  butterfly_unit latency, cycles (operand in to operand_a/b_out)
// PORTS
//  clk             in   1      clock
//  rst             in   1      synchronous reset, active-high
//  start           in   1      begin a run; sampled only in IDLE
//  mode            in   2      0 = forward NTT, 1 = inverse NTT, 2 = element-wise; 3 treated as 0; sampled with start
//  busy            out  1      high from the cycle after start is accepted until done
//  done            out  1      one-cycle pulse after the last write-back of the run
//  rd_valid        out  1      rd_addr_a/b, tw_addr valid this cycle
//  rd_addr_a       out  LOG_N  coefficient read address, operand a
//  rd_addr_b       out  LOG_N  coefficient read address, operand b
//  tw_addr         out  LOG_N  twiddle-table index
//  bfu_forward     out  1      to butterfly_unit.forward
//  bfu_element_wise out 1      to butterfly_unit.element_wise
//  wr_en           out  1      write operand_a/b_out back this cycle
//  wr_addr_a       out  LOG_N  write address for operand_a_out
//  wr_addr_b       out  LOG_N  write address for operand_b_out
// BEHAVIOUR
//  Fixed rules:
//  - Reset: FSM = IDLE; every output = 0; delay line cleared (no wr_en after reset, even mid-run).
//  - PIPE = RD_LAT + BFU_LAT. The {rd_valid, rd_addr_a, rd_addr_b} of cycle c reappear as {wr_en, wr_addr_a, wr_addr_b} at cycle c+PIPE (shift register).
//  - bfu_forward = (mode != 1) and bfu_element_wise = (mode == 2); both latched at start and held until the next start.
//  FSM: IDLE -> ISSUE -> DRAIN -> (ISSUE of next stage | DONE) -> IDLE.
//  - IDLE: start=1 -> ISSUE at stage s=0, k=0; start is ignored in every other state.
//  - ISSUE: rd_valid=1 and k increments each cycle.
//    - NTT/INTT: k runs 0..N/2-1. Element-wise: k runs 0..N-1 and there is only one stage.
//    - After the last k -> DRAIN with a down-counter loaded with PIPE.
//  - DRAIN: exactly PIPE cycles with rd_valid=0.
//    - Then, if s < LOG_N-1: s++, k=0, back to ISSUE; otherwise -> DONE.
//  - DONE: done=1 for one cycle, busy=0 -> IDLE. The next start is accepted in that IDLE cycle.
//  Address generation (k = butterfly index, s = stage):
//  - Forward (Cooley-Tukey): t = N>>(s+1); j = k>>(LOG_N-1-s); i = k&(t-1);
//    rd_addr_a = 2*j*t + i; rd_addr_b = rd_addr_a + t; tw_addr = (1<<s) + j.
//  - Inverse (Gentleman-Sande): t = 1<<s; j = k>>s; i = k&(t-1); same a/b formulas; tw_addr = (N>>(s+1)) + j.
//  - Element-wise: rd_addr_a = rd_addr_b = k, tw_addr = 0 (butterfly multiplies a*b).
//  - Use shifts and masks only; no multipliers. All addresses are LOG_N bits; no address exceeds N-1.
//  Timing:
//  - Start accepted at cycle 0 -> first rd_valid at cycle 1.
//  - NTT/INTT run length = LOG_N*(N/2 + PIPE) cycles; done at cycle LOG_N*(N/2+PIPE)+1.
//  - Element-wise: done at cycle N+PIPE+1.
//  - rst mid-run aborts at once: no further rd_valid, wr_en or done.
// TESTING
//  1 LOG_N=3, mode=0: stage0 pairs (0,4)(1,5)(2,6)(3,7) tw 1,1,1,1; stage1 (0,2)(1,3)(4,6)(5,7) tw 2,2,3,3;
//    stage2 (0,1)(2,3)(4,5)(6,7) tw 4,5,6,7.
//  2 LOG_N=3, mode=1: stage0 pairs (0,1)..(6,7) tw 4..7; stage2 pairs (0,4)..(3,7) tw 1; bfu_forward=0 throughout.
//  3 LOG_N=3, RD_LAT=1, BFU_LAT=17, mode=0: rd_valid at cycles 1-4, 23-26, 45-48; wr_en at 19-22, 41-44, 63-66;
//    done only at 67.
//  4 mode=2, LOG_N=3: rd_addr_a=rd_addr_b=0..7 at cycles 1-8; bfu_element_wise=1; wr_en at 19-26; done at 27.
//  5 start re-pulsed while busy: ignored, sequence identical to test 3; start held high through done: second run begins.
//  6 rst at cycle 30 of test 3: all outputs 0 from cycle 31; no wr_en/done afterwards; new start runs cleanly.

Source files
------------

// File: rtl/ntt_stage_sequencer_if.sv
// Handshake and address bus between ntt_stage_sequencer (master) and the
// controller / coefficient-RAM / butterfly_unit side (slave).
interface ntt_stage_sequencer_if #(
   parameter int LOG_N = 4
) ();
   logic             start;
   logic [1:0]       mode;
   logic             busy;
   logic             done;
   logic             rd_valid;
   logic [LOG_N-1:0] rd_addr_a;
   logic [LOG_N-1:0] rd_addr_b;
   logic [LOG_N-1:0] tw_addr;
   logic             bfu_forward;
   logic             bfu_element_wise;
   logic             wr_en;
   logic [LOG_N-1:0] wr_addr_a;
   logic [LOG_N-1:0] wr_addr_b;

   modport master (
      input  start, mode,
      output busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
             bfu_forward, bfu_element_wise, wr_en, wr_addr_a, wr_addr_b
   );

   modport slave (
      output start, mode,
      input  busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr,
             bfu_forward, bfu_element_wise, wr_en, wr_addr_a, wr_addr_b
   );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// Stage/butterfly sequencer for an NTT engine: issues read and twiddle addresses
// one butterfly per cycle and replays them, delayed by the datapath latency, as write-backs.
module ntt_stage_sequencer #(
   parameter int LOG_N   = 4,
   parameter int RD_LAT  = 1,
   parameter int BFU_LAT = 17
) (
   input logic                   clk,
   input logic                   rst,
   ntt_stage_sequencer_if.master bus
);
   localparam int PIPE = RD_LAT + BFU_LAT;
   localparam int S_W  = $clog2(LOG_N + 1);
   localparam int C_W  = $clog2(PIPE + 1);
   localparam int E_W  = 2 * LOG_N + 1;

   localparam logic [LOG_N:0]   N_FULL     = {1'b1, {LOG_N{1'b0}}};
   localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);
   localparam logic [LOG_N-1:0] K_LAST_NTT = LOG_N'((1 << (LOG_N - 1)) - 1);
   localparam logic [S_W-1:0]   S_LAST     = S_W'(LOG_N - 1);
   localparam logic [C_W-1:0]   DRAIN_LOAD = C_W'(PIPE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;
   typedef enum logic [1:0] {M_FWD = 2'd0, M_INV = 2'd1, M_EW = 2'd2} mode_e;

   // Returns {tw_addr, rd_addr_b, rd_addr_a} for butterfly k of stage s.
   function automatic logic [3*LOG_N-1:0] addr_gen(input logic [S_W-1:0]   s,
                                                   input logic [LOG_N-1:0] k,
                                                   input mode_e            m);
      logic [LOG_N-1:0] t, j, i, a, b, tw;
      t = '0; j = '0; i = '0; a = '0; b = '0; tw = '0;
      case (m)
         M_FWD: begin
            t  = LOG_N'(N_FULL >> (s + S_W'(1)));
            j  = k >> (S_LAST - s);
            i  = k & (t - ONE);
            a  = (j << (S_W'(LOG_N) - s)) + i;
            b  = a + t;
            tw = (ONE << s) + j;
         end
         M_INV: begin
            t  = ONE << s;
            j  = k >> s;
            i  = k & (t - ONE);
            a  = (j << (s + S_W'(1))) + i;
            b  = a + t;
            tw = LOG_N'(N_FULL >> (s + S_W'(1))) + j;
         end
         M_EW: begin
            a  = k;
            b  = k;
            tw = '0;
         end
         default: begin
            a  = '0;
            b  = '0;
            tw = '0;
         end
      endcase
      return {tw, b, a};
   endfunction

   state_e           state_q;
   mode_e            mode_q, mode_d, issue_m_d;
   logic [S_W-1:0]   stage_q, issue_s_d;
   logic [LOG_N-1:0] k_q, issue_k_d, k_last_d;
   logic [C_W-1:0]   cnt_q;
   logic             busy_q, done_q, rd_valid_q, fwd_q, ew_q;
   logic [LOG_N-1:0] rd_a_q, rd_b_q, tw_q;
   logic [3*LOG_N-1:0] addr_d;
   logic [E_W-1:0]   wb_pipe_q [PIPE];

   // Mode decode plus the (stage, k) whose addresses get registered on this edge.
   always_comb begin
      case (bus.mode)
         2'd1:    mode_d = M_INV;
         2'd2:    mode_d = M_EW;
         default: mode_d = M_FWD;
      endcase
      issue_s_d = '0;
      issue_k_d = '0;
      issue_m_d = mode_q;
      case (state_q)
         ST_IDLE:  issue_m_d = mode_d;
         ST_ISSUE: begin
            issue_s_d = stage_q;
            issue_k_d = k_q + ONE;
         end
         ST_DRAIN: issue_s_d = stage_q + S_W'(1);
         default:  issue_s_d = '0;
      endcase
      if (mode_q == M_EW) begin
         k_last_d = '1;
      end else begin
         k_last_d = K_LAST_NTT;
      end
      addr_d = addr_gen(issue_s_d, issue_k_d, issue_m_d);
   end

   // Run-control FSM with registered read-side outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         mode_q     <= M_FWD;
         stage_q    <= '0;
         k_q        <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         fwd_q      <= 1'b0;
         ew_q       <= 1'b0;
         {tw_q, rd_b_q, rd_a_q} <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  state_q    <= ST_ISSUE;
                  mode_q     <= mode_d;
                  fwd_q      <= (mode_d != M_INV);
                  ew_q       <= (mode_d == M_EW);
                  stage_q    <= '0;
                  k_q        <= '0;
                  busy_q     <= 1'b1;
                  rd_valid_q <= 1'b1;
                  {tw_q, rd_b_q, rd_a_q} <= addr_d;
               end
            end
            ST_ISSUE: begin
               if (k_q == k_last_d) begin
                  state_q    <= ST_DRAIN;
                  cnt_q      <= DRAIN_LOAD;
                  rd_valid_q <= 1'b0;
                  {tw_q, rd_b_q, rd_a_q} <= '0;
               end else begin
                  k_q <= k_q + ONE;
                  {tw_q, rd_b_q, rd_a_q} <= addr_d;
               end
            end
            ST_DRAIN: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - C_W'(1);
               end else if (mode_q == M_EW || stage_q == S_LAST) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= ST_ISSUE;
                  stage_q    <= stage_q + S_W'(1);
                  k_q        <= '0;
                  rd_valid_q <= 1'b1;
                  {tw_q, rd_b_q, rd_a_q} <= addr_d;
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Read request replayed PIPE cycles later as the write-back request.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < PIPE; n++) wb_pipe_q[n] <= '0;
      end else begin
         wb_pipe_q[0] <= {rd_valid_q, rd_b_q, rd_a_q};
         for (int n = 1; n < PIPE; n++) wb_pipe_q[n] <= wb_pipe_q[n-1];
      end
   end

   assign bus.busy             = busy_q;
   assign bus.done             = done_q;
   assign bus.rd_valid         = rd_valid_q;
   assign bus.rd_addr_a        = rd_a_q;
   assign bus.rd_addr_b        = rd_b_q;
   assign bus.tw_addr          = tw_q;
   assign bus.bfu_forward      = fwd_q;
   assign bus.bfu_element_wise = ew_q;
   assign {bus.wr_en, bus.wr_addr_b, bus.wr_addr_a} = wb_pipe_q[PIPE-1];
endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench for ntt_stage_sequencer: a run-level reference model queues expected
// reads, write-backs and done pulses; a negedge monitor pops and compares them.
module tb_ntt_stage_sequencer;
   localparam int LOG_N   = 3;
   localparam int RD_LAT  = 1;
   localparam int BFU_LAT = 17;
   localparam int PIPE    = RD_LAT + BFU_LAT;
   localparam int N       = 1 << LOG_N;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ntt_stage_sequencer_if #(.LOG_N(LOG_N)) bus ();

   ntt_stage_sequencer #(.LOG_N(LOG_N), .RD_LAT(RD_LAT), .BFU_LAT(BFU_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {int c; int a; int b; int tw; bit fwd; bit ew;} ev_t;
   ev_t rdq[$];
   ev_t wrq[$];
   int  doneq[$];
   ev_t e_rd, e_wr;
   int  cyc    = 0;
   int  n_chk  = 0;
   int  n_pass = 0;
   bit  mon_en = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(bit ok, string name, string got, string exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s at cycle %0d: got %s, expected %s", name, cyc, got, exp);
   endfunction

   // Expected events for a run accepted at cycle c0; returns the done cycle.
   function automatic int push_run(int c0, logic [1:0] m);
      bit inv = (m == 2'd1);
      bit ew  = (m == 2'd2);
      int nst = ew ? 1 : LOG_N;
      int per = ew ? N : N / 2;
      int c   = c0 + 1;
      for (int s = 0; s < nst; s++) begin
         for (int k = 0; k < per; k++) begin
            int t, j, i, a, b, tw;
            if (ew) begin
               a = k; b = k; tw = 0;
            end else if (inv) begin
               t = 1 << s; j = k >> s; i = k % t;
               a = 2 * j * t + i; b = a + t; tw = (N >> (s + 1)) + j;
            end else begin
               t = N >> (s + 1); j = k >> (LOG_N - 1 - s); i = k % t;
               a = 2 * j * t + i; b = a + t; tw = (1 << s) + j;
            end
            rdq.push_back('{c, a, b, tw, !inv, ew});
            wrq.push_back('{c + PIPE, a, b, 0, 1'b0, 1'b0});
            c++;
         end
         c += PIPE;
      end
      doneq.push_back(c);
      return c;
   endfunction

   function automatic void flush_after(int lim);
      ev_t r[$];
      ev_t w[$];
      int  d[$];
      foreach (rdq[n]) if (rdq[n].c <= lim) r.push_back(rdq[n]);
      foreach (wrq[n]) if (wrq[n].c <= lim) w.push_back(wrq[n]);
      foreach (doneq[n]) if (doneq[n] <= lim) d.push_back(doneq[n]);
      rdq = r; wrq = w; doneq = d;
   endfunction

   function automatic bit all_zero();
      return {bus.busy, bus.done, bus.rd_valid, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
              bus.bfu_forward, bus.bfu_element_wise, bus.wr_en, bus.wr_addr_a,
              bus.wr_addr_b} === '0;
   endfunction

   // Monitor: compares every presented read, write-back and done against the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         while (rdq.size() > 0 && rdq[0].c < cyc) begin
            chk(1'b0, "rd_missing", "no rd_valid", $sformatf("rd at cycle %0d", rdq[0].c));
            void'(rdq.pop_front());
         end
         while (wrq.size() > 0 && wrq[0].c < cyc) begin
            chk(1'b0, "wr_missing", "no wr_en", $sformatf("wr at cycle %0d", wrq[0].c));
            void'(wrq.pop_front());
         end
         while (doneq.size() > 0 && doneq[0] < cyc) begin
            chk(1'b0, "done_missing", "no done", $sformatf("done at cycle %0d", doneq[0]));
            void'(doneq.pop_front());
         end
         if (bus.rd_valid === 1'b1) begin
            if (rdq.size() == 0 || rdq[0].c != cyc) begin
               chk(1'b0, "rd_unexpected", $sformatf("a=%0d b=%0d", bus.rd_addr_a, bus.rd_addr_b),
                   "rd_valid=0");
            end else begin
               e_rd = rdq.pop_front();
               chk(int'(bus.rd_addr_a) == e_rd.a && int'(bus.rd_addr_b) == e_rd.b &&
                   int'(bus.tw_addr) == e_rd.tw && bus.bfu_forward == e_rd.fwd &&
                   bus.bfu_element_wise == e_rd.ew && bus.busy === 1'b1, "rd_issue",
                   $sformatf("a=%0d b=%0d tw=%0d fwd=%0b ew=%0b busy=%0b", bus.rd_addr_a,
                             bus.rd_addr_b, bus.tw_addr, bus.bfu_forward,
                             bus.bfu_element_wise, bus.busy),
                   $sformatf("a=%0d b=%0d tw=%0d fwd=%0b ew=%0b busy=1", e_rd.a, e_rd.b,
                             e_rd.tw, e_rd.fwd, e_rd.ew));
            end
         end
         if (bus.wr_en === 1'b1) begin
            if (wrq.size() == 0 || wrq[0].c != cyc) begin
               chk(1'b0, "wr_unexpected", $sformatf("a=%0d b=%0d", bus.wr_addr_a, bus.wr_addr_b),
                   "wr_en=0");
            end else begin
               e_wr = wrq.pop_front();
               chk(int'(bus.wr_addr_a) == e_wr.a && int'(bus.wr_addr_b) == e_wr.b, "wr_back",
                   $sformatf("a=%0d b=%0d", bus.wr_addr_a, bus.wr_addr_b),
                   $sformatf("a=%0d b=%0d", e_wr.a, e_wr.b));
            end
         end
         if (bus.done === 1'b1) begin
            if (doneq.size() == 0 || doneq[0] != cyc) begin
               chk(1'b0, "done_unexpected", "done=1", "done=0");
            end else begin
               void'(doneq.pop_front());
               chk(bus.busy === 1'b0, "done_busy", $sformatf("busy=%0b", bus.busy), "busy=0");
            end
         end
      end
   end

   // One run from the IDLE cycle, optionally with ignored start pulses and mode noise.
   task automatic run(input logic [1:0] m, input bit pulses, input int exp_len);
      int c0, n;
      c0 = cyc;
      bus.start = 1'b1;
      bus.mode  = m;
      void'(push_run(c0, m));
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 300) begin
         if (pulses) begin
            bus.start = ($urandom_range(0, 3) == 0);
            bus.mode  = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         n++;
      end
      bus.start = 1'b0;
      chk(bus.done === 1'b1 && cyc - c0 == exp_len, "done_cycle",
          $sformatf("done=%0b at +%0d", bus.done, cyc - c0), $sformatf("done=1 at +%0d", exp_len));
      @(negedge clk);
   endtask

   initial begin
      int c0, d1, n;
      logic [1:0] m;
      bus.start = 1'b0;
      bus.mode  = 2'd0;
      repeat (3) @(negedge clk);
      chk(all_zero(), "reset_state", "some output nonzero", "all outputs 0");
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      run(2'd0, 1'b0, 67);
      run(2'd1, 1'b0, 67);
      run(2'd2, 1'b0, 27);
      run(2'd0, 1'b1, 67);

      // start held high through done: second run accepted in the IDLE cycle
      c0 = cyc;
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      d1 = push_run(c0, 2'd0);
      while (cyc < d1 + 1) @(negedge clk);
      c0 = cyc;
      void'(push_run(c0, 2'd0));
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk(bus.done === 1'b1 && cyc - c0 == 67, "held_start_second_run",
          $sformatf("done=%0b at +%0d", bus.done, cyc - c0), "done=1 at +67");
      @(negedge clk);

      // reset in the middle of a forward run
      c0 = cyc;
      bus.start = 1'b1;
      bus.mode  = 2'd0;
      void'(push_run(c0, 2'd0));
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < c0 + 30) @(negedge clk);
      rst = 1'b1;
      flush_after(c0 + 30);
      @(negedge clk);
      chk(all_zero(), "reset_midrun", "some output nonzero", "all outputs 0");
      rst = 1'b0;
      repeat (80) @(negedge clk);
      chk(all_zero(), "after_reset_quiet", "some output nonzero", "all outputs 0");
      run(2'd2, 1'b0, 27);

      for (int r = 0; r < 12; r++) begin
         m = 2'($urandom_range(0, 3));
         repeat ($urandom_range(0, 4)) @(negedge clk);
         run(m, 1'b1, (m == 2'd2) ? N + PIPE + 1 : LOG_N * (N / 2 + PIPE) + 1);
      end

      repeat (PIPE + 5) @(negedge clk);
      chk(rdq.size() == 0 && wrq.size() == 0 && doneq.size() == 0, "queues_empty",
          $sformatf("rd=%0d wr=%0d done=%0d left", rdq.size(), wrq.size(), doneq.size()),
          "all empty");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
